// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full_adder cell time-shared over WIDTH clocks, LSB first.
// Ports:
//   clk, rst_n      - rising-edge clock, async active-low reset
//   start           - request; accepted only in IDLE
//   a, b, cin       - operands, captured on the accepted start edge
//   busy            - high while bits are being processed
//   done            - one-cycle completion strobe
//   sum, cout       - registered result of the last completed add

// 1-bit full adder cell.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module serial_adder_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_d, done_d, cout_d;
  logic [WIDTH-1:0] sum_d;
  logic             fa_s, fa_co;

  // Single shared adder cell fed from the operand LSBs and the carry flop.
  full_adder u_fa (
    .a  (a_sh_q[0]),
    .b  (b_sh_q[0]),
    .ci (carry_q),
    .s  (fa_s),
    .co (fa_co)
  );

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      sum_sh_q <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      sum      <= '0;
      cout     <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      sum_sh_q <= sum_sh_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      busy     <= busy_d;
      done     <= done_d;
      sum      <= sum_d;
      cout     <= cout_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    sum_sh_d = sum_sh_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    busy_d   = busy;
    done_d   = 1'b0;
    sum_d    = sum;
    cout_d   = cout;

    case (state_q)
      IDLE: begin
        if (start) begin
          a_sh_d   = a;
          b_sh_d   = b;
          sum_sh_d = '0;
          carry_d  = cin;
          cnt_d    = '0;
          busy_d   = 1'b1;
          state_d  = RUN;
        end
      end
      RUN: begin
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        // New sum bit enters at the MSB; after WIDTH shifts bit 0 lands at position 0.
        sum_sh_d = (sum_sh_q >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));
        carry_d  = fa_co;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          cnt_d   = '0;
          sum_d   = sum_sh_d;
          cout_d  = fa_co;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl: a WIDTH=8 and a WIDTH=1 instance,
// checked against arithmetic a+b+cin and the accept/done cycle timing.
module tb_serial_adder_ctrl;

  logic       clk;
  logic       rst_n;

  logic       start8, cin8, busy8, done8, cout8;
  logic [7:0] a8, b8, sum8;

  logic       start1, cin1, busy1, done1, cout1;
  logic [0:0] a1, b1, sum1;

  int n_assert = 0;
  int n_fail   = 0;

  logic [7:0] last_sum  = '0;
  logic       last_cout = 1'b0;

  serial_adder_ctrl #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );

  serial_adder_ctrl #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .cin(cin1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One WIDTH=8 add. repulse in 1..8 re-asserts start (zero operands) on RUN edge
  // t0+repulse; repulse==9 asserts it on the edge leaving DONE.
  task automatic add8(input logic [7:0] a, input logic [7:0] b, input logic c, input int repulse);
    logic [8:0] exp;
    exp = 9'(a) + 9'(b) + 9'(c);
    start8 = 1'b1; a8 = a; b8 = b; cin8 = c;
    tick();
    start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
    for (int k = 1; k <= 8; k++) begin
      chk("run_busy", busy8, 1'b1);
      chk("run_done", done8, 1'b0);
      chk("run_sum_hold", sum8, last_sum);
      chk("run_cout_hold", cout8, last_cout);
      if (k == repulse) begin
        start8 = 1'b1; a8 = 8'h00; b8 = 8'h00; cin8 = 1'b0;
      end else begin
        start8 = 1'b0;
      end
      tick();
    end
    chk("cmp_busy", busy8, 1'b0);
    chk("cmp_done", done8, 1'b1);
    chk("cmp_sum", sum8, exp[7:0]);
    chk("cmp_cout", cout8, exp[8]);
    last_sum  = exp[7:0];
    last_cout = exp[8];
    start8 = (repulse == 9);
    tick();
    start8 = 1'b0;
    chk("post_done", done8, 1'b0);
    chk("post_busy", busy8, 1'b0);
    chk("post_sum", sum8, last_sum);
  endtask

  initial begin
    int acc, next_acc;
    logic [8:0] exp_q;
    logic [1:0] tot;

    rst_n = 1'b0;
    start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
    #2;
    chk("rst_busy8", busy8, 1'b0);
    chk("rst_done8", done8, 1'b0);
    chk("rst_sum8", sum8, 8'h00);
    chk("rst_cout8", cout8, 1'b0);
    chk("rst_busy1", busy1, 1'b0);
    chk("rst_sum1", sum1, 1'b0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Directed adds, including carry-out and all-ones cases.
    add8(8'h5A, 8'h3C, 1'b0, 0);
    add8(8'hFF, 8'h01, 1'b0, 0);
    add8(8'hFF, 8'hFF, 1'b1, 0);
    // start during RUN and during DONE is ignored.
    add8(8'h5A, 8'h3C, 1'b0, 3);
    add8(8'h81, 8'h7E, 1'b1, 9);

    // Reset mid-RUN abandons the add.
    start8 = 1'b1; a8 = 8'h5A; b8 = 8'h3C; cin8 = 1'b1;
    tick();
    start8 = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy8, 1'b0);
    chk("mid_rst_done", done8, 1'b0);
    chk("mid_rst_sum", sum8, 8'h00);
    chk("mid_rst_cout", cout8, 1'b0);
    for (int k = 0; k < 2; k++) begin
      tick();
      chk("in_rst_done", done8, 1'b0);
    end
    rst_n = 1'b1;
    last_sum = 8'h00; last_cout = 1'b0;
    tick();
    chk("after_rst_done", done8, 1'b0);
    add8(8'h10, 8'h20, 1'b0, 0);

    // start held high: accepts every WIDTH+2 edges with freshly changing operands.
    acc = -100; next_acc = 0; exp_q = '0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      start8 = 1'b1; a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
      if (cyc == next_acc) exp_q = 9'(a8) + 9'(b8) + 9'(cin8);
      tick();
      if (cyc == next_acc) begin
        acc = cyc;
        next_acc = cyc + 10;
      end
      chk("b2b_busy", busy8, (cyc >= acc) && (cyc < acc + 8));
      chk("b2b_done", done8, cyc == acc + 8);
      if (cyc == acc + 8) begin
        last_sum = exp_q[7:0]; last_cout = exp_q[8];
      end
      chk("b2b_sum", sum8, last_sum);
      chk("b2b_cout", cout8, last_cout);
    end
    start8 = 1'b0;
    tick();
    tick();

    // Random operands.
    for (int i = 0; i < 6; i++) add8(8'($urandom), 8'($urandom), 1'($urandom), 0);

    // WIDTH=1 instance: full-adder truth table.
    for (int i = 0; i < 8; i++) begin
      a1 = 1'(i >> 2); b1 = 1'(i >> 1); cin1 = 1'(i);
      tot = 2'(a1) + 2'(b1) + 2'(cin1);
      start1 = 1'b1;
      tick();
      start1 = 1'b0;
      chk("w1_busy", busy1, 1'b1);
      chk("w1_run_done", done1, 1'b0);
      tick();
      chk("w1_done", done1, 1'b1);
      chk("w1_busy_off", busy1, 1'b0);
      chk("w1_sum", sum1, tot[0]);
      chk("w1_cout", cout1, tot[1]);
      tick();
      chk("w1_done_off", done1, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
